uart_rx_ctrl: RTL and testbench

//  Receive-side sequencer for the UART peripheral. Divides clk into oversample ticks and validates start bits.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART configuration types
package uart_pkg;

  typedef enum logic {
    STOP_BITS_1 = 1'b0,
    STOP_BITS_2 = 1'b1
  } stop_bits_t;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_t;

endpackage

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer with frame FIFO
// Optional UART_RX_CTRL_MAJORITY_EN: 2-of-3 majority vote around the bit centre.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [3:0]       num_data_bits,
  input  stop_bits_t       stop_bits,
  input  parity_t          parity,
  input  logic             rx,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_parity_err,
  output logic             m_frame_err,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [SC_W-1:0] MID     = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] MID_M1  = SC_W'(OVERSAMPLE / 2 - 2);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
`ifdef UART_RX_CTRL_MAJORITY_EN
  localparam logic [SC_W-1:0] SAMP_AT = SC_W'(OVERSAMPLE / 2);
`else
  localparam logic [SC_W-1:0] SAMP_AT = MID;
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2
  } state_t;

  state_t           state, state_n;
  logic             rx_m, rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [SC_W-1:0]  sc;
  logic [3:0]       bit_idx, nbits_l;
  stop_bits_t       stop_l;
  parity_t          par_l;
  logic [7:0]       data;
  logic             perr, ferr;
  logic             samp, at_samp, sc_last, last_bit, push;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign tick = en && (div_cnt == baud_div);

  always_ff @(posedge clk) begin
    if (rst || !en || tick) div_cnt <= '0;
    else                    div_cnt <= div_cnt + DIV_W'(1);
  end

`ifdef UART_RX_CTRL_MAJORITY_EN
  logic s_pre, s_mid;
  always_ff @(posedge clk) begin
    if (rst) begin
      s_pre <= 1'b1;
      s_mid <= 1'b1;
    end else if (tick && state != ST_IDLE) begin
      if (sc == MID_M1) s_pre <= rx_s;
      if (sc == MID)    s_mid <= rx_s;
    end
  end
  assign samp = (s_pre & s_mid) | (s_pre & rx_s) | (s_mid & rx_s);
`else
  assign samp = rx_s;
`endif

  assign at_samp  = (sc == SAMP_AT);
  assign sc_last  = (sc == SC_LAST);
  assign last_bit = (bit_idx == nbits_l - 4'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    push    = 1'b0;
    if (!en) begin
      state_n = ST_IDLE;
    end else if (tick) begin
      unique case (state)
        ST_IDLE:   if (!rx_s) state_n = ST_START;
        ST_START:  if (at_samp && samp) state_n = ST_IDLE;
                   else if (sc_last)    state_n = ST_DATA;
        ST_DATA:   if (sc_last && last_bit)
                     state_n = (par_l != PARITY_NONE) ? ST_PARITY : ST_STOP1;
        ST_PARITY: if (sc_last) state_n = ST_STOP1;
        // Single stop bit releases at mid-bit so the next start edge is never missed.
        ST_STOP1:  if (at_samp && stop_l == STOP_BITS_1) begin
                     push    = 1'b1;
                     state_n = ST_IDLE;
                   end else if (sc_last) begin
                     state_n = ST_STOP2;
                   end
        ST_STOP2:  if (at_samp) begin
                     push    = 1'b1;
                     state_n = ST_IDLE;
                   end
        default:   state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      sc      <= '0;
      bit_idx <= '0;
      nbits_l <= 4'd8;
      stop_l  <= STOP_BITS_1;
      par_l   <= PARITY_NONE;
      data    <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else if (tick) begin
      if (state == ST_IDLE) begin
        sc      <= '0;
        bit_idx <= '0;
        data    <= '0;
        perr    <= 1'b0;
        ferr    <= 1'b0;
        if (!rx_s) begin
          nbits_l <= (num_data_bits < 4'd5 || num_data_bits > 4'd8) ? 4'd8 : num_data_bits;
          stop_l  <= stop_bits;
          par_l   <= parity;
        end
      end else begin
        sc <= sc_last ? '0 : sc + SC_W'(1);
        case (state)
          ST_DATA: begin
            if (at_samp) data[bit_idx[2:0]] <= samp;
            if (sc_last) bit_idx <= bit_idx + 4'd1;
          end
          ST_PARITY: if (at_samp)
            perr <= (par_l == PARITY_EVEN) ? (^data ^ samp) : ~(^data ^ samp);
          ST_STOP1, ST_STOP2: if (at_samp) ferr <= ferr | ~samp;
          default: ;
        endcase
      end
    end
  end

  logic [9:0]     mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic           empty, full, pop, wr_en;
  logic [9:0]     head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop   = m_valid & m_ready;
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= {data, perr, ferr | ~samp};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (push && !wr_en) overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  assign head         = mem[rd_ptr[PTR_W-1:0]];
  assign m_valid      = ~empty;
  assign m_data       = m_valid ? head[9:2] : 8'h00;
  assign m_parity_err = m_valid & head[1];
  assign m_frame_err  = m_valid & head[0];
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, rx, m_ready, clr_overrun;
  logic [15:0] baud_div;
  logic [3:0]  num_data_bits;
  stop_bits_t  stop_bits;
  parity_t     parity;
  logic        m_valid, m_parity_err, m_frame_err, busy, overrun;
  logic [7:0]  m_data;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;

  uart_rx_ctrl #(.OVERSAMPLE(16), .FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .baud_div(baud_div),
    .num_data_bits(num_data_bits), .stop_bits(stop_bits), .parity(parity),
    .rx(rx), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_parity_err(m_parity_err), .m_frame_err(m_frame_err), .busy(busy),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && m_valid && m_ready) begin
      pops++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pop: observed data %0h expected no frame", m_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("m_data", m_data, e.d);
        check("m_parity_err", m_parity_err, e.pe);
        check("m_frame_err", m_frame_err, e.fe);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rx = (glitch && i == 8) ? ~b : b;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic use_par,
                            input logic par_bit, input int nstop, input logic stop2_val,
                            input int glitch_bit);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nb; i++) send_bit(d[i], glitch_bit == i);
    if (use_par) send_bit(par_bit, 1'b0);
    send_bit(1'b1, 1'b0);
    if (nstop == 2) send_bit(stop2_val, 1'b0);
    @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    check(tag, sb.size(), 0);
  endtask

  task automatic cfg(input logic [3:0] nb, input stop_bits_t sbits, input parity_t p);
    num_data_bits = nb;
    stop_bits     = sbits;
    parity        = p;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    rst = 1'b1; en = 1'b1; rx = 1'b1; m_ready = 1'b1; clr_overrun = 1'b0;
    baud_div = 16'd0;
    cfg(4'd8, STOP_BITS_1, PARITY_NONE);
    idle(3);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_perr", m_parity_err, 0);
    check("rst_ferr", m_frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    idle(20);

    // 8N1 0xA5
    p0 = pops;
    sb.push_back('{8'hA5, 1'b0, 1'b0});
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    check("t1_busy", busy, 0);
    idle(32);
    drain("t1_drain");
    check("t1_pop_count", pops - p0, 1);

    // 7E1 with wrong parity bit
    cfg(4'd7, STOP_BITS_1, PARITY_EVEN);
    sb.push_back('{8'h35, 1'b1, 1'b0});
    send_frame(8'h35, 7, 1'b1, 1'b1, 1, 1'b1, -1);
    idle(32);
    drain("t2_drain");

    // 8N2: bad second stop, then clean
    cfg(4'd8, STOP_BITS_2, PARITY_NONE);
    sb.push_back('{8'h3C, 1'b0, 1'b1});
    send_frame(8'h3C, 8, 1'b0, 1'b0, 2, 1'b0, -1);
    idle(40);
    sb.push_back('{8'h3C, 1'b0, 1'b0});
    send_frame(8'h3C, 8, 1'b0, 1'b0, 2, 1'b1, -1);
    idle(32);
    drain("t3_drain");

    // false start
    cfg(4'd8, STOP_BITS_1, PARITY_NONE);
    p0 = pops;
    @(negedge clk); rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(16);
    check("t4_busy", busy, 0);
    idle(24);
    check("t4_no_push", m_valid, 0);
    check("t4_pop_count", pops - p0, 0);
    sb.push_back('{8'h55, 1'b0, 1'b0});
    send_frame(8'h55, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    idle(32);
    drain("t4_drain");

    // 5-bit frame and out-of-range width clamp
    cfg(4'd5, STOP_BITS_1, PARITY_ODD);
    sb.push_back('{8'h15, 1'b0, 1'b0});
    send_frame(8'h15, 5, 1'b1, 1'b0, 1, 1'b1, -1);
    idle(32);
    cfg(4'd3, STOP_BITS_1, PARITY_NONE);
    sb.push_back('{8'hC3, 1'b0, 1'b0});
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    idle(32);
    drain("t5a_drain");

    // overrun with consumer stalled
    cfg(4'd8, STOP_BITS_1, PARITY_NONE);
    m_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) sb.push_back('{8'(k), 1'b0, 1'b0});
      send_frame(8'(k), 8, 1'b0, 1'b0, 1, 1'b1, -1);
      idle(32);
      if (k == 4) check("t5_overrun_before", overrun, 0);
    end
    check("t5_m_valid", m_valid, 1);
    check("t5_overrun", overrun, 1);
    m_ready = 1'b1;
    drain("t5_drain");
    idle(10);
    check("t5_empty", m_valid, 0);
    check("t5_overrun_held", overrun, 1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("t5_clr_overrun", overrun, 0);

    // reset in the middle of a frame
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    idle(8);
    check("t6_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_m_valid", m_valid, 0);
    idle(80);
    sb.push_back('{8'h81, 1'b0, 1'b0});
    send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b1, -1);
    idle(32);
    drain("t6_drain");

`ifdef UART_RX_CTRL_MAJORITY_EN
    sb.push_back('{8'hA5, 1'b0, 1'b0});
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, 2);
    idle(32);
    drain("t7_glitch_drain");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
